// File: rtl/cookie_spawner_if.sv
// Player-facing bus of the cookie spawner.
// The game controller drives the master side; the spawner is the slave.
interface cookie_spawner_if;
    logic        en;
    logic [15:0] rnd_number;
    logic [7:0]  btn;
    logic [7:0]  cookie;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        hit;
    logic        miss;
    logic        game_over;

    modport master (
        output en, rnd_number, btn,
        input  cookie, score, lives, hit, miss, game_over
    );

    modport slave (
        input  en, rnd_number, btn,
        output cookie, score, lives, hit, miss, game_over
    );
endinterface

// File: rtl/cookie_spawner.sv
// Whack-a-cookie round controller.
// It shows one cookie per round, scores presses and counts down lives.
module cookie_spawner #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic             clk,
    input logic             rst_n,
    cookie_spawner_if.slave bus
);
    typedef enum logic [1:0] {GAP, SHOW, OVER} state_t;

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  prev_q, prev_d;
    logic [2:0]  slot;
    logic [7:0]  btn_q;
    logic [7:0]  press;
    logic [7:0]  cookie_q, cookie_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        wrong, right;
    logic        unused_rnd;

    assign unused_rnd = ^bus.rnd_number[15:3];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        cookie_d = cookie_q;
        score_d  = score_q;
        lives_d  = lives_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        press    = bus.btn & ~btn_q;
        wrong    = |(press & ~cookie_q);
        right    = |(press & cookie_q);
        slot     = bus.rnd_number[2:0];
        if (slot == prev_q)
            slot = prev_q + 3'd1;

        unique case (state_q)
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d  = SHOW;
                    cnt_d    = 16'd0;
                    cookie_d = 8'd1 << slot;
                    prev_d   = slot;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHOW: begin
                // A stray press beats a correct one in the same cycle.
                if (wrong || (!right && cnt_q == TO_LAST)) begin
                    miss_d   = 1'b1;
                    cookie_d = 8'd0;
                    cnt_d    = 16'd0;
                    lives_d  = lives_q - 2'd1;
                    state_d  = (lives_q == 2'd1) ? OVER : GAP;
                end else if (right) begin
                    hit_d    = 1'b1;
                    cookie_d = 8'd0;
                    cnt_d    = 16'd0;
                    state_d  = GAP;
                    if (score_q != 8'hFF)
                        score_d = score_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            OVER: begin
                cookie_d = 8'd0;
            end
            default: begin
                state_d = GAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GAP;
            cnt_q    <= 16'd0;
            prev_q   <= 3'd0;
            btn_q    <= 8'd0;
            cookie_q <= 8'd0;
            score_q  <= 8'd0;
            lives_q  <= 2'd3;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else if (bus.en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            btn_q    <= bus.btn;
            cookie_q <= cookie_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
        end
    end

    assign bus.cookie    = cookie_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.hit       = hit_q;
    assign bus.miss      = miss_q;
    assign bus.game_over = (state_q == OVER);
endmodule

// File: tb/tb_cookie_spawner.sv
// Directed bench for cookie_spawner with GAP=4, TIMEOUT=8.
// Each task drives one scenario and checks its own results.
module tb_cookie_spawner;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] exp_score;
    logic [2:0] exp_prev;
    logic [7:0] exp_cookie;

    cookie_spawner_if bus ();

    cookie_spawner #(
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] next_cookie(input logic [2:0] r);
        logic [2:0] s;
        s = (r == exp_prev) ? r + 3'd1 : r;
        exp_prev = s;
        return 8'd1 << s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.btn = 8'd0;
        bus.rnd_number = 16'd0;
        step(2);
        checks++;
        if (bus.cookie !== 8'd0 || bus.score !== 8'd0 || bus.lives !== 2'd3) begin
            errors++;
            $display("FAIL reset_regs: cookie=%h score=%0d lives=%0d want 00/0/3",
                     bus.cookie, bus.score, bus.lives);
        end
        checks++;
        if (bus.hit !== 1'b0 || bus.miss !== 1'b0 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: hit=%b miss=%b go=%b want 0/0/0",
                     bus.hit, bus.miss, bus.game_over);
        end
        rst_n = 1'b1;
        bus.en = 1'b1;
    endtask

    task automatic test_first_cookie();
        bus.rnd_number = 16'h0005;
        step(3);
        checks++;
        if (bus.cookie !== 8'd0) begin
            errors++;
            $display("FAIL early_cookie: got %h want 00", bus.cookie);
        end
        step(1);
        checks++;
        if (bus.cookie !== 8'h20) begin
            errors++;
            $display("FAIL first_cookie: got %h want 20", bus.cookie);
        end
        exp_prev = 3'd5;
    endtask

    task automatic test_hit();
        bus.btn = 8'h20;
        step(1);
        checks++;
        if (bus.hit !== 1'b1 || bus.miss !== 1'b0 || bus.score !== 8'd1
            || bus.cookie !== 8'd0) begin
            errors++;
            $display("FAIL hit: hit=%b miss=%b score=%0d cookie=%h want 1/0/1/00",
                     bus.hit, bus.miss, bus.score, bus.cookie);
        end
        bus.btn = 8'h00;
        step(1);
        checks++;
        if (bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_pulse_len: hit=%b want 0", bus.hit);
        end
        step(2);
        checks++;
        if (bus.cookie !== 8'd0) begin
            errors++;
            $display("FAIL gap_restart: cookie=%h want 00", bus.cookie);
        end
        step(1);
        checks++;
        if (bus.cookie !== 8'h40) begin
            errors++;
            $display("FAIL repeat_avoid: cookie=%h want 40", bus.cookie);
        end
        exp_prev = 3'd6;
    endtask

    task automatic test_timeout();
        step(7);
        checks++;
        if (bus.miss !== 1'b0 || bus.cookie !== 8'h40) begin
            errors++;
            $display("FAIL pre_timeout: miss=%b cookie=%h want 0/40",
                     bus.miss, bus.cookie);
        end
        step(1);
        checks++;
        if (bus.miss !== 1'b1 || bus.hit !== 1'b0 || bus.lives !== 2'd2
            || bus.cookie !== 8'd0) begin
            errors++;
            $display("FAIL timeout: miss=%b hit=%b lives=%0d cookie=%h want 1/0/2/00",
                     bus.miss, bus.hit, bus.lives, bus.cookie);
        end
        bus.rnd_number = 16'h0006;
        step(4);
        checks++;
        if (bus.cookie !== 8'h80 || bus.miss !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout: cookie=%h miss=%b want 80/0",
                     bus.cookie, bus.miss);
        end
        exp_prev = 3'd7;
    endtask

    task automatic test_wrong_press();
        bus.btn = 8'h81;
        step(1);
        checks++;
        if (bus.miss !== 1'b1 || bus.hit !== 1'b0 || bus.lives !== 2'd1
            || bus.score !== 8'd1) begin
            errors++;
            $display("FAIL wrong_wins: miss=%b hit=%b lives=%0d score=%0d want 1/0/1/1",
                     bus.miss, bus.hit, bus.lives, bus.score);
        end
        bus.rnd_number = 16'h0007;
        step(4);
        checks++;
        if (bus.cookie !== 8'h01) begin
            errors++;
            $display("FAIL slot_wrap: cookie=%h want 01", bus.cookie);
        end
        step(1);
        checks++;
        if (bus.hit !== 1'b0 || bus.miss !== 1'b0 || bus.cookie !== 8'h01) begin
            errors++;
            $display("FAIL held_btn: hit=%b miss=%b cookie=%h want 0/0/01",
                     bus.hit, bus.miss, bus.cookie);
        end
        bus.btn = 8'h00;
        step(1);
        exp_prev = 3'd0;
    endtask

    task automatic test_saturate();
        bus.btn = 8'h01;
        step(1);
        exp_score = 8'd2;
        checks++;
        if (bus.hit !== 1'b1 || bus.score !== exp_score) begin
            errors++;
            $display("FAIL sat_first: hit=%b score=%0d want 1/%0d",
                     bus.hit, bus.score, exp_score);
        end
        for (int i = 0; i < 254; i++) begin
            bus.btn = 8'h00;
            bus.rnd_number = 16'(i * 3);
            exp_cookie = next_cookie(3'(i * 3));
            step(4);
            checks++;
            if (bus.cookie !== exp_cookie) begin
                errors++;
                $display("FAIL sat_cookie[%0d]: got %h want %h",
                         i, bus.cookie, exp_cookie);
            end
            bus.btn = exp_cookie;
            step(1);
            if (exp_score != 8'hFF)
                exp_score = exp_score + 8'd1;
            checks++;
            if (bus.hit !== 1'b1 || bus.miss !== 1'b0 || bus.score !== exp_score) begin
                errors++;
                $display("FAIL sat_hit[%0d]: hit=%b miss=%b score=%0d want 1/0/%0d",
                         i, bus.hit, bus.miss, bus.score, exp_score);
            end
        end
        checks++;
        if (bus.score !== 8'hFF) begin
            errors++;
            $display("FAIL sat_final: score=%0d want 255", bus.score);
        end
    endtask

    task automatic test_freeze();
        bus.btn = 8'h00;
        bus.rnd_number = 16'h0002;
        exp_cookie = next_cookie(3'd2);
        step(4);
        checks++;
        if (bus.cookie !== exp_cookie) begin
            errors++;
            $display("FAIL freeze_show: cookie=%h want %h", bus.cookie, exp_cookie);
        end
        step(3);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.rnd_number = 16'(i);
            step(1);
        end
        checks++;
        if (bus.cookie !== exp_cookie || bus.hit !== 1'b0 || bus.miss !== 1'b0
            || bus.score !== 8'hFF || bus.lives !== 2'd1) begin
            errors++;
            $display("FAIL frozen: cookie=%h hit=%b miss=%b score=%0d lives=%0d",
                     bus.cookie, bus.hit, bus.miss, bus.score, bus.lives);
        end
        bus.en = 1'b1;
        step(4);
        checks++;
        if (bus.miss !== 1'b0 || bus.cookie !== exp_cookie) begin
            errors++;
            $display("FAIL resume_timer: miss=%b cookie=%h want 0/%h",
                     bus.miss, bus.cookie, exp_cookie);
        end
        step(1);
        checks++;
        if (bus.miss !== 1'b1 || bus.lives !== 2'd0 || bus.game_over !== 1'b1
            || bus.cookie !== 8'd0) begin
            errors++;
            $display("FAIL last_miss: miss=%b lives=%0d go=%b cookie=%h want 1/0/1/00",
                     bus.miss, bus.lives, bus.game_over, bus.cookie);
        end
    endtask

    task automatic test_game_over();
        step(1);
        checks++;
        if (bus.miss !== 1'b0) begin
            errors++;
            $display("FAIL over_miss_pulse: miss=%b want 0", bus.miss);
        end
        for (int i = 0; i < 12; i++) begin
            bus.btn = (i % 2 == 0) ? 8'hFF : 8'h00;
            step(1);
        end
        checks++;
        if (bus.cookie !== 8'd0 || bus.score !== 8'hFF || bus.game_over !== 1'b1
            || bus.hit !== 1'b0 || bus.lives !== 2'd0) begin
            errors++;
            $display("FAIL over_hold: cookie=%h score=%0d go=%b hit=%b lives=%0d",
                     bus.cookie, bus.score, bus.game_over, bus.hit, bus.lives);
        end
        bus.btn = 8'h00;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.lives !== 2'd3 || bus.score !== 8'd0 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL over_reset: lives=%0d score=%0d go=%b want 3/0/0",
                     bus.lives, bus.score, bus.game_over);
        end
    endtask

    task automatic test_reset_mid_show();
        step(1);
        rst_n = 1'b1;
        bus.rnd_number = 16'h0005;
        step(4);
        checks++;
        if (bus.cookie !== 8'h20) begin
            errors++;
            $display("FAIL rst_cookie: cookie=%h want 20", bus.cookie);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cookie !== 8'd0 || bus.hit !== 1'b0 || bus.miss !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: cookie=%h hit=%b miss=%b want 00/0/0",
                     bus.cookie, bus.hit, bus.miss);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_prev = 3'd0;
        exp_score = 8'd0;
        exp_cookie = 8'd0;
        test_reset();
        test_first_cookie();
        test_hit();
        test_timeout();
        test_wrong_press();
        test_saturate();
        test_freeze();
        test_game_over();
        test_reset_mid_show();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
